// File: rtl/route_comp_pipe_pkg.sv
// Shared port-index constants and lane-state encoding for the XY route-computation pipeline.
package route_comp_pipe_pkg;

  localparam int PORT_XP    = 0;
  localparam int PORT_XN    = 1;
  localparam int PORT_YP    = 2;
  localparam int PORT_YN    = 3;
  localparam int PORT_LOCAL = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } laneState_t;

endpackage

// File: rtl/route_comp_pipe_route_vec_calc.sv
// Combinational destination -> productive-port vector for one lane.
// Define TORUS_WRAP_EN to pick the shorter ring direction in each dimension.
module route_vec_calc
  import route_comp_pipe_pkg::*;
#(
  parameter int WIDTH_COORDINATE = 3,
  parameter int NUM_PORT         = 5,
  parameter int CUR_X            = 0,
  parameter int CUR_Y            = 0,
  parameter int MESH_X           = 8,
  parameter int MESH_Y           = 8
) (
  input  logic [WIDTH_COORDINATE-1:0] dstX,
  input  logic [WIDTH_COORDINATE-1:0] dstY,
  output logic [NUM_PORT-1:0]         prodVec
);

  localparam int W = WIDTH_COORDINATE;
  localparam logic [W:0] CurXExt = (W+1)'(CUR_X);
  localparam logic [W:0] CurYExt = (W+1)'(CUR_Y);

  logic [W:0] dX;
  logic [W:0] dY;
  logic       nzX;
  logic       nzY;
  logic       signX;
  logic       signY;
  logic       xPos;
  logic       xNeg;
  logic       yPos;
  logic       yNeg;

  // One extra bit keeps the difference signed so the MSB is the direction.
  assign dX    = {1'b0, dstX} - CurXExt;
  assign dY    = {1'b0, dstY} - CurYExt;
  assign nzX   = |dX;
  assign nzY   = |dY;
  assign signX = dX[W];
  assign signY = dY[W];

`ifdef TORUS_WRAP_EN
  localparam logic [W:0] HalfX = (W+1)'(MESH_X / 2);
  localparam logic [W:0] HalfY = (W+1)'(MESH_Y / 2);

  logic [W:0] magX;
  logic [W:0] magY;
  logic       wrapX;
  logic       wrapY;

  // A tie at exactly half the ring keeps the mesh direction.
  assign magX  = signX ? -dX : dX;
  assign magY  = signY ? -dY : dY;
  assign wrapX = magX > HalfX;
  assign wrapY = magY > HalfY;
  assign xPos  = nzX & ~(signX ^ wrapX);
  assign xNeg  = nzX &  (signX ^ wrapX);
  assign yPos  = nzY & ~(signY ^ wrapY);
  assign yNeg  = nzY &  (signY ^ wrapY);
`else
  assign xPos = nzX & ~signX;
  assign xNeg = nzX &  signX;
  assign yPos = nzY & ~signY;
  assign yNeg = nzY &  signY;
`endif

  always_comb begin
    prodVec             = '0;
    prodVec[PORT_XP]    = xPos;
    prodVec[PORT_XN]    = xNeg;
    prodVec[PORT_YP]    = yPos;
    prodVec[PORT_YN]    = yNeg;
    prodVec[PORT_LOCAL] = ~nzX & ~nzY;
  end

endmodule

// File: rtl/route_comp_pipe.sv
// Registered multi-lane XY route computation with per-packet route hold and valid/ready lanes.
// Optional TORUS_WRAP_EN selects shortest-ring routing inside route_vec_calc.
module route_comp_pipe
  import route_comp_pipe_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int WIDTH_COORDINATE = 3,
  parameter int NUM_PORT         = 5,
  parameter int CUR_X            = 0,
  parameter int CUR_Y            = 0,
  parameter int MESH_X           = 8,
  parameter int MESH_Y           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CH-1:0]                  in_valid,
  input  logic [NUM_CH-1:0]                  in_head,
  input  logic [NUM_CH-1:0]                  in_tail,
  input  logic [NUM_CH*WIDTH_COORDINATE-1:0] in_dstX,
  input  logic [NUM_CH*WIDTH_COORDINATE-1:0] in_dstY,
  output logic [NUM_CH-1:0]                  in_ready,
  output logic [NUM_CH-1:0]                  out_valid,
  output logic [NUM_CH*NUM_PORT-1:0]         out_prodVec,
  output logic [NUM_CH-1:0]                  out_head,
  output logic [NUM_CH-1:0]                  out_tail,
  input  logic [NUM_CH-1:0]                  out_ready,
  output logic [NUM_CH-1:0]                  proto_err
);

  localparam int W = WIDTH_COORDINATE;

  for (genvar c = 0; c < NUM_CH; c++) begin : gLane
    laneState_t          state;
    logic [NUM_PORT-1:0] calcVec;
    logic [NUM_PORT-1:0] routeReg;
    logic [NUM_PORT-1:0] outVec;
    logic                outValid;
    logic                outHead;
    logic                outTail;
    logic                protoErr;
    logic                accept;

    route_vec_calc #(
      .WIDTH_COORDINATE(WIDTH_COORDINATE),
      .NUM_PORT        (NUM_PORT),
      .CUR_X           (CUR_X),
      .CUR_Y           (CUR_Y),
      .MESH_X          (MESH_X),
      .MESH_Y          (MESH_Y)
    ) uCalc (
      .dstX   (in_dstX[c*W +: W]),
      .dstY   (in_dstY[c*W +: W]),
      .prodVec(calcVec)
    );

    assign in_ready[c] = ~outValid | out_ready[c];
    assign accept      = in_valid[c] & in_ready[c];

    // A head seen mid-packet is flagged but still starts a fresh packet.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        routeReg <= '0;
        outVec   <= '0;
        outValid <= 1'b0;
        outHead  <= 1'b0;
        outTail  <= 1'b0;
        protoErr <= 1'b0;
      end else if (accept) begin
        outValid <= 1'b1;
        outHead  <= in_head[c];
        outTail  <= in_tail[c];
        if (in_head[c]) begin
          if (state == PKT) protoErr <= 1'b1;
          outVec <= calcVec;
          if (in_tail[c]) begin
            state <= IDLE;
          end else begin
            state    <= PKT;
            routeReg <= calcVec;
          end
        end else if (state == PKT) begin
          outVec <= routeReg;
          if (in_tail[c]) state <= IDLE;
        end else begin
          outVec   <= '0;
          protoErr <= 1'b1;
        end
      end else if (out_ready[c]) begin
        outValid <= 1'b0;
      end
    end

    assign out_valid[c]                     = outValid;
    assign out_head[c]                      = outHead;
    assign out_tail[c]                      = outTail;
    assign out_prodVec[c*NUM_PORT +: NUM_PORT] = outVec;
    assign proto_err[c]                     = protoErr;
  end

endmodule

// File: tb/tb_route_comp_pipe.sv
// Self-checking bench for route_comp_pipe: vector table, corner sequences and random traffic vs a reference model.
module tb_route_comp_pipe;

  localparam int NCH    = 2;
  localparam int WC     = 3;
  localparam int NP     = 5;
  localparam int CURX   = 2;
  localparam int CURY   = 2;
  localparam int MESHX  = 8;
  localparam int MESHY  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH-1:0]   in_head = '0;
  logic [NCH-1:0]   in_tail = '0;
  logic [NCH*WC-1:0] in_dstX = '0;
  logic [NCH*WC-1:0] in_dstY = '0;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   out_valid;
  logic [NCH*NP-1:0] out_prodVec;
  logic [NCH-1:0]   out_head;
  logic [NCH-1:0]   out_tail;
  logic [NCH-1:0]   out_ready = '0;
  logic [NCH-1:0]   proto_err;

  int checks = 0;
  int failures = 0;

  route_comp_pipe #(
    .NUM_CH(NCH), .WIDTH_COORDINATE(WC), .NUM_PORT(NP),
    .CUR_X(CURX), .CUR_Y(CURY), .MESH_X(MESHX), .MESH_Y(MESHY)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_dstX(in_dstX), .in_dstY(in_dstY), .in_ready(in_ready), .out_valid(out_valid),
    .out_prodVec(out_prodVec), .out_head(out_head), .out_tail(out_tail),
    .out_ready(out_ready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model state: what each lane's output register should hold.
  bit             mValid [NCH];
  bit             mHead  [NCH];
  bit             mTail  [NCH];
  bit             mErr   [NCH];
  bit             mInPkt [NCH];
  logic [NP-1:0]  mVec   [NCH];
  logic [NP-1:0]  mHeld  [NCH];

  // Route rule from signed coordinate distances.
  function automatic logic [NP-1:0] refVec(int x, int y);
    int dx;
    int dy;
    logic [NP-1:0] v;
    dx = x - CURX;
    dy = y - CURY;
`ifdef TORUS_WRAP_EN
    if ((dx < 0 ? -dx : dx) > MESHX / 2) dx = -dx;
    if ((dy < 0 ? -dy : dy) > MESHY / 2) dy = -dy;
`endif
    v    = '0;
    v[0] = dx > 0;
    v[1] = dx < 0;
    v[2] = dy > 0;
    v[3] = dy < 0;
    v[4] = (dx == 0) && (dy == 0);
    return v;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mValid[c] = 0; mHead[c] = 0; mTail[c] = 0; mErr[c] = 0;
      mInPkt[c] = 0; mVec[c] = '0; mHeld[c] = '0;
    end
  endtask

  task automatic modelStep();
    bit acc [NCH];
    for (int c = 0; c < NCH; c++) acc[c] = in_valid[c] && (!mValid[c] || out_ready[c]);
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        mValid[c] = 1;
        mHead[c]  = in_head[c];
        mTail[c]  = in_tail[c];
        if (in_head[c]) begin
          if (mInPkt[c]) mErr[c] = 1;
          mVec[c]   = refVec(int'(in_dstX[c*WC +: WC]), int'(in_dstY[c*WC +: WC]));
          mInPkt[c] = !in_tail[c];
          if (!in_tail[c]) mHeld[c] = mVec[c];
        end else if (mInPkt[c]) begin
          mVec[c] = mHeld[c];
          if (in_tail[c]) mInPkt[c] = 0;
        end else begin
          mVec[c] = '0;
          mErr[c] = 1;
        end
      end else if (out_ready[c]) begin
        mValid[c] = 0;
      end
    end
  endtask

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NCH-1:0]    eV, eH, eT, eE;
    logic [NCH*NP-1:0] eP;
    for (int c = 0; c < NCH; c++) begin
      eV[c] = mValid[c]; eH[c] = mHead[c]; eT[c] = mTail[c]; eE[c] = mErr[c];
      eP[c*NP +: NP] = mVec[c];
    end
    compare("out_valid", 32'(out_valid), 32'(eV));
    compare("out_prodVec", 32'(out_prodVec), 32'(eP));
    compare("out_head", 32'(out_head), 32'(eH));
    compare("out_tail", 32'(out_tail), 32'(eT));
    compare("proto_err", 32'(proto_err), 32'(eE));
  endtask

  // Inputs must already be driven; checks in_ready, clocks once, then checks the registers.
  task automatic applyStimulus();
    logic [NCH-1:0] eR;
    #1;
    for (int c = 0; c < NCH; c++) eR[c] = !mValid[c] || out_ready[c];
    compare("in_ready", 32'(in_ready), 32'(eR));
    @(posedge clk);
    modelStep();
    #1 checkOutput();
  endtask

  task automatic setLane(int c, bit v, bit h, bit t, int x, int y);
    in_valid[c] = v;
    in_head[c]  = h;
    in_tail[c]  = t;
    in_dstX[c*WC +: WC] = WC'(x);
    in_dstY[c*WC +: WC] = WC'(y);
  endtask

  typedef struct {
    bit            head;
    bit            tail;
    int            x;
    int            y;
    logic [NP-1:0] expVec;
  } vecRec_t;

  vecRec_t tbl [9];

  initial begin
    logic [NP-1:0] drained [$];
    int            sentX [$];
    int            pendX [$];
    bit            acc0;

    tbl[0] = '{1, 1, 2, 2, 5'b10000};
    tbl[1] = '{1, 0, 5, 0, 5'b01001};
    tbl[2] = '{0, 0, 0, 0, 5'b01001};
    tbl[3] = '{0, 0, 0, 0, 5'b01001};
    tbl[4] = '{0, 1, 0, 0, 5'b01001};
    tbl[5] = '{1, 1, 0, 4, 5'b00110};
`ifdef TORUS_WRAP_EN
    tbl[6] = '{1, 1, 7, 2, 5'b00010};
`else
    tbl[6] = '{1, 1, 7, 2, 5'b00001};
`endif
    tbl[7] = '{1, 1, 6, 2, 5'b00001};
    tbl[8] = '{1, 1, 2, 0, 5'b01000};

    modelReset();
    #12 checkOutput();
    @(posedge clk); #1 reset = 1'b0;

    // Table-driven vectors on lane 0; body flits carry random destinations.
    out_ready = 2'b11;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].head) setLane(0, 1, 1, tbl[i].tail, tbl[i].x, tbl[i].y);
      else setLane(0, 1, 0, tbl[i].tail, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      applyStimulus();
      compare($sformatf("tbl%0d_vec", i), 32'(out_prodVec[NP-1:0]), 32'(tbl[i].expVec));
      compare($sformatf("tbl%0d_valid", i), 32'(out_valid[0]), 32'd1);
    end
    setLane(0, 0, 0, 0, 0, 0);
    applyStimulus();

    // Backpressure: three single flits against a stalled output, then drain.
    pendX = '{5, 0, 7};
    sentX = pendX;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready[0] = (cyc >= 3);
      if (pendX.size() > 0) setLane(0, 1, 1, 1, pendX[0], 3);
      else setLane(0, 0, 0, 0, 0, 0);
      #1;
      if (mValid[0] && out_ready[0]) drained.push_back(out_prodVec[NP-1:0]);
      acc0 = in_valid[0] && (!mValid[0] || out_ready[0]);
      applyStimulus();
      if (acc0) void'(pendX.pop_front());
      if (pendX.size() == 0 && !mValid[0] && !acc0) break;
    end
    compare("drain_count", 32'(drained.size()), 32'(sentX.size()));
    for (int i = 0; i < drained.size() && i < sentX.size(); i++)
      compare($sformatf("drain%0d", i), 32'(drained[i]), 32'(refVec(sentX[i], 3)));

    // Body flit on an idle lane emits a zero vector and sets the sticky error.
    out_ready = 2'b11;
    setLane(1, 1, 0, 0, 3, 3);
    applyStimulus();
    compare("idle_body_err", 32'(proto_err[1]), 32'd1);
    setLane(1, 1, 1, 1, 2, 2);
    applyStimulus();
    compare("err_sticky", 32'(proto_err[1]), 32'd1);

    // Reset mid-packet on lane 1 while lane 0 streams.
    setLane(1, 1, 1, 0, 4, 4);
    setLane(0, 1, 1, 1, 1, 1);
    applyStimulus();
    setLane(1, 1, 0, 0, 0, 0);
    applyStimulus();
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutput();
    in_valid = '0;
    @(posedge clk); #1 reset = 1'b0;
    checkOutput();
    setLane(1, 1, 0, 0, 0, 0);
    applyStimulus();
    compare("post_reset_body_err", 32'(proto_err[1]), 32'd1);
    compare("post_reset_lane0_err", 32'(proto_err[0]), 32'd0);

    // Random traffic on both lanes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        setLane(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        out_ready[c] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
